// File: rtl/result_writeback_unit_pkg.sv
// Shared definitions for the result writeback path: drain FSM state codes and default widths
// so the wrapper top can instantiate with matching DATA_W/BATCH.
package result_writeback_unit_pkg;

   localparam int unsigned WB_DATA_W = 16;
   localparam int unsigned WB_DEPTH  = 4;
   localparam int unsigned WB_ADDR_W = 8;
   localparam int unsigned WB_BATCH  = 4;

   typedef enum logic {
      WB_IDLE  = 1'b0,
      WB_ISSUE = 1'b1
   } wb_state_e;

endpackage

// File: rtl/result_writeback_unit_sync_fifo.sv
// Synchronous FIFO with registered full/empty derived from the occupancy count.
// A push into a full FIFO is ignored even if a pop happens on the same edge.
module sync_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d, empty_q, empty_d;
   logic              push_ok, pop_ok;

   assign push_ok = push_i && !full_q;
   assign pop_ok  = pop_i && !empty_q;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_ok) begin
         mem_d[wptr_q] = data_i;
         wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rptr_d = rptr_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - CNT_W'(1);
      end
      full_d  = (count_d == CNT_W'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/result_writeback_unit.sv
// Buffers per-pass results and drains them to result memory over a req/ack port with an
// auto-incrementing address, batch-complete pulse and sticky overflow flag.
module result_writeback_unit
   import result_writeback_unit_pkg::*;
#(
   parameter int unsigned DATA_W = WB_DATA_W,
   parameter int unsigned DEPTH  = WB_DEPTH,
   parameter int unsigned ADDR_W = WB_ADDR_W,
   parameter int unsigned BATCH  = WB_BATCH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_req,
   input  logic [DATA_W-1:0]      wr_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   mem_wr,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_data,
   input  logic                   mem_ack,
   output logic                   batch_done,
   output logic                   overflow
);

   localparam int unsigned BAT_W = $clog2(BATCH + 1);

   wb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [BAT_W-1:0]  bcnt_q, bcnt_d;
   logic              bdone_q, bdone_d;
   logic              ovf_q, ovf_d;
   logic              pop;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full, fifo_empty;

   assign pop = (state_q == WB_ISSUE) && mem_ack;

   sync_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i  (clk),
      .rst_i  (rst),
      .push_i (wr_req),
      .data_i (wr_data),
      .pop_i  (pop),
      .head_o (fifo_head),
      .count_o(count),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      bcnt_d  = bcnt_q;
      bdone_d = 1'b0;
      ovf_d   = ovf_q | (wr_req & fifo_full);
      unique case (state_q)
         WB_IDLE: begin
            if (!fifo_empty) begin
               state_d = WB_ISSUE;
               data_d  = fifo_head;
            end
         end
         WB_ISSUE: begin
            if (mem_ack) begin
               state_d = WB_IDLE;
               addr_d  = addr_q + ADDR_W'(1);
               if (bcnt_q == BAT_W'(BATCH - 1)) begin
                  bcnt_d  = '0;
                  bdone_d = 1'b1;
               end else begin
                  bcnt_d = bcnt_q + BAT_W'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WB_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         bcnt_q  <= '0;
         bdone_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         bcnt_q  <= bcnt_d;
         bdone_q <= bdone_d;
         ovf_q   <= ovf_d;
      end
   end

   assign mem_wr     = (state_q == WB_ISSUE);
   assign mem_addr   = addr_q;
   assign mem_data   = data_q;
   assign batch_done = bdone_q;
   assign overflow   = ovf_q;
   assign full       = fifo_full;
   assign empty      = fifo_empty;

endmodule

// File: tb/tb_result_writeback_unit.sv
// Self-checking bench: queue-based reference model of the writeback unit plus directed and
// randomized scenarios; acked writes are logged and compared against the model.
module tb_result_writeback_unit;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;
   localparam int BATCH  = 4;

   logic              clk = 1'b0;
   logic              rst, wr_req, mem_ack;
   logic [DATA_W-1:0] wr_data;
   logic              full, empty, mem_wr, batch_done, overflow;
   logic [2:0]        count;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] mq [$];
   int                m_addr, m_batch, bd_bad, bd_obs, sb_under;
   bit                m_ovf, bd_exp;
   logic [ADDR_W-1:0] obs_addr [$];
   logic [ADDR_W-1:0] exp_addr [$];
   logic [DATA_W-1:0] obs_data [$];
   logic [DATA_W-1:0] exp_data [$];

   result_writeback_unit #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W),
      .BATCH (BATCH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_req    (wr_req),
      .wr_data   (wr_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_ack   (mem_ack),
      .batch_done(batch_done),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Advance one clock; the model applies the same edge using the pre-edge inputs/handshake.
   task automatic tick();
      bit                accept, pop;
      logic [DATA_W-1:0] w;
      if (rst) begin
         mq.delete();
         m_addr  = 0;
         m_batch = 0;
         m_ovf   = 1'b0;
         bd_exp  = 1'b0;
      end else begin
         accept = (mq.size() < DEPTH);
         pop    = (mem_wr === 1'b1) && (mem_ack === 1'b1);
         bd_exp = 1'b0;
         if (pop) begin
            if (mq.size() == 0) begin
               sb_under++;
               w = '0;
            end else begin
               w = mq.pop_front();
            end
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_data);
            exp_addr.push_back(ADDR_W'(m_addr));
            exp_data.push_back(w);
            m_addr = (m_addr + 1) % (1 << ADDR_W);
            m_batch++;
            if (m_batch == BATCH) begin
               m_batch = 0;
               bd_exp  = 1'b1;
            end
         end
         if (wr_req) begin
            if (accept) mq.push_back(wr_data);
            else m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (batch_done === 1'b1) bd_obs++;
      if (batch_done !== bd_exp) bd_bad++;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      wr_req  = 1'b0;
      mem_ack = 1'b0;
      tick();
      tick();
      rst    = 1'b0;
      bd_obs = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
      checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
      checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL reset_bd got %b want 0", batch_done); end
   endtask

   task automatic test_single();
      do_reset();
      wr_req = 1'b1; wr_data = 16'hA5A5;
      tick();
      wr_req = 1'b0;
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", mem_wr); end
      tick();
      checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL single_wr got %b want 1", mem_wr); end
      checks++; if (mem_addr !== 2'd0) begin errors++; $display("FAIL single_addr got %0d want 0", mem_addr); end
      checks++; if (mem_data !== 16'hA5A5) begin errors++; $display("FAIL single_data got %h want a5a5", mem_data); end
      tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++; if (mem_addr !== 2'd1) begin errors++; $display("FAIL single_addr_inc got %0d want 1", mem_addr); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL single_wr_drop got %b want 0", mem_wr); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", empty); end
   endtask

   task automatic test_batch();
      int base;
      do_reset();
      base    = obs_addr.size();
      mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_req = 1'b1; wr_data = DATA_W'($urandom);
         tick();
         wr_req = 1'b0;
         tick();
         tick();
      end
      for (int i = 0; i < 4; i++) tick();
      mem_ack = 1'b0;
      checks++;
      if (obs_addr.size() - base != 4) begin
         errors++; $display("FAIL batch_writes got %0d want 4", obs_addr.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_addr[base+i] !== ADDR_W'(i)) begin
               errors++; $display("FAIL batch_addr[%0d] got %0d want %0d", i, obs_addr[base+i], i);
            end
         end
      end
      checks++; if (bd_obs != 1) begin errors++; $display("FAIL batch_pulses got %0d want 1", bd_obs); end
   endtask

   task automatic test_overflow();
      int base;
      do_reset();
      base = obs_addr.size();
      for (int i = 0; i < 5; i++) begin
         wr_req = 1'b1; wr_data = DATA_W'($urandom);
         tick();
         if (i == 3) begin
            checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", full); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
         end
      end
      wr_req = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", count); end
      tick();
      tick();
      mem_ack = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      mem_ack = 1'b0;
      checks++;
      if (obs_addr.size() - base != 4) begin
         errors++; $display("FAIL ovf_writes got %0d want 4", obs_addr.size() - base);
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b want 1", empty); end
   endtask

   task automatic test_stall();
      logic [ADDR_W-1:0] a0;
      logic [DATA_W-1:0] d0;
      int                n;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         wr_req = 1'b1; wr_data = DATA_W'($urandom);
         tick();
      end
      wr_req = 1'b0;
      n = 0;
      while (mem_wr !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL stall_wait got %b want 1", mem_wr); end
      a0 = mem_addr;
      d0 = mem_data;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (mem_wr !== 1'b1 || mem_addr !== a0 || mem_data !== d0) begin
            errors++;
            $display("FAIL stall_hold got wr=%b a=%0d d=%h want wr=1 a=%0d d=%h", mem_wr, mem_addr,
                     mem_data, a0, d0);
         end
      end
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL stall_count got %0d want 2", count); end
      mem_ack = 1'b1; wr_req = 1'b1; wr_data = DATA_W'($urandom);
      tick();
      wr_req = 1'b0;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count got %0d want 2", count); end
      for (int i = 0; i < 10; i++) tick();
      mem_ack = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stall_drain got %b want 1", empty); end
   endtask

   task automatic test_wrap_reset();
      logic [ADDR_W-1:0] want [6];
      int                base, n;
      want[0] = 2'd0; want[1] = 2'd1; want[2] = 2'd2;
      want[3] = 2'd3; want[4] = 2'd0; want[5] = 2'd1;
      do_reset();
      base    = obs_addr.size();
      mem_ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_req = 1'b1; wr_data = DATA_W'($urandom);
         tick();
         wr_req = 1'b0;
         tick();
         tick();
      end
      mem_ack = 1'b0;
      checks++;
      if (obs_addr.size() - base != 6) begin
         errors++; $display("FAIL wrap_writes got %0d want 6", obs_addr.size() - base);
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_addr[base+i] !== want[i]) begin
               errors++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i, obs_addr[base+i], want[i]);
            end
         end
      end
      wr_req = 1'b1; wr_data = DATA_W'($urandom);
      tick();
      wr_req = 1'b0;
      n = 0;
      while (mem_wr !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL wrap_wait got %b want 1", mem_wr); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mid_wr got %b want 0", mem_wr); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_mid_empty got %b want 1", empty); end
      checks++; if (mem_addr !== 2'd0) begin errors++; $display("FAIL rst_mid_addr got %0d want 0", mem_addr); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_mid_count got %0d want 0", count); end
   endtask

   task automatic test_random();
      logic [2:0] want_cnt;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         wr_req  = ($urandom_range(0, 9) < 4);
         wr_data = DATA_W'($urandom);
         mem_ack = ($urandom_range(0, 1) == 1);
         tick();
         want_cnt = 3'(mq.size());
         checks++;
         if (count !== want_cnt) begin
            errors++; $display("FAIL rand_count cycle %0d got %0d want %0d", i, count, want_cnt);
         end
      end
      wr_req  = 1'b0;
      mem_ack = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      mem_ack = 1'b0;
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf got %b want %b", overflow, m_ovf); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rand_empty got %b want 1", empty); end
   endtask

   task automatic test_scoreboard();
      for (int i = 0; i < obs_addr.size(); i++) begin
         checks++;
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            errors++;
            $display("FAIL write[%0d] got a=%0d d=%h want a=%0d d=%h", i, obs_addr[i], obs_data[i],
                     exp_addr[i], exp_data[i]);
         end
      end
      checks++; if (bd_bad != 0) begin errors++; $display("FAIL batch_done_timing got %0d bad cycles want 0", bd_bad); end
      checks++; if (sb_under != 0) begin errors++; $display("FAIL write_when_empty got %0d want 0", sb_under); end
   endtask

   initial begin
      rst      = 1'b1;
      wr_req   = 1'b0;
      mem_ack  = 1'b0;
      wr_data  = '0;
      bd_bad   = 0;
      bd_obs   = 0;
      sb_under = 0;
      @(negedge clk);
      test_reset();
      test_single();
      test_batch();
      test_overflow();
      test_stall();
      test_wrap_reset();
      test_random();
      test_scoreboard();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
